// File: rtl/kick_command_issuer.sv
// Kick command issuer: accepts a strength request, waits for the ball, fires, then cools down.
// Optional WAIT_IR timeout is enabled by defining the macro KICK_IR_TIMEOUT_EN.
module kick_command_issuer #(
  parameter int HOLD_CYCLES       = 16,
  parameter int COOLDOWN_CYCLES   = 1000000,
  parameter int IR_TIMEOUT_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [3:0] cmd_strength,
  input  logic       cmd_abort,
  input  logic       ir,
  input  logic       trigger_in,
  output logic       cmd_ready,
  output logic       kickstart,
  output logic [6:0] kicktime,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [7:0] kick_count
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_IR  = 2'd1;
  localparam logic [1:0] S_FIRE     = 2'd2;
  localparam logic [1:0] S_COOLDOWN = 2'd3;

  // Counters hold "cycles already spent"; a phase ends in the cycle its counter reads LAST.
  localparam int HOLD_LAST = (HOLD_CYCLES > 1) ? HOLD_CYCLES - 1 : 0;
  localparam int HOLD_W    = (HOLD_LAST > 0) ? $clog2(HOLD_LAST + 1) : 1;
  localparam int CD_LAST   = (COOLDOWN_CYCLES > 1) ? COOLDOWN_CYCLES - 1 : 0;
  localparam int CD_W      = (CD_LAST > 0) ? $clog2(CD_LAST + 1) : 1;

  logic [1:0]        state_reg, state_next;
  logic [3:0]        strength_reg, strength_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [CD_W-1:0]   cd_cnt_reg, cd_cnt_next;
  logic              done_reg, done_next;
  logic [7:0]        kick_count_reg, kick_count_next;
  logic              wait_expired;

  function automatic logic [6:0] strength_code(input logic [3:0] s);
    logic [6:0] c;
    case (s)
      4'd0:    c = 7'b0000000;
      4'd1:    c = 7'b0000001;
      4'd2:    c = 7'b0000011;
      4'd3:    c = 7'b0000111;
      4'd4:    c = 7'b0011111;
      4'd5:    c = 7'b1000000;
      4'd6:    c = 7'b1100000;
      4'd7:    c = 7'b1110000;
      4'd8:    c = 7'b1111000;
      4'd9:    c = 7'b1111100;
      default: c = 7'b1111110;
    endcase
    return c;
  endfunction

`ifdef KICK_IR_TIMEOUT_EN
  localparam int IRT_LAST = (IR_TIMEOUT_CYCLES > 1) ? IR_TIMEOUT_CYCLES - 1 : 0;
  localparam int IRT_W    = (IRT_LAST > 0) ? $clog2(IRT_LAST + 1) : 1;

  logic [IRT_W-1:0] ir_cnt_reg, ir_cnt_next;
  logic             timeout_reg, timeout_next;

  assign wait_expired = (ir_cnt_reg == IRT_W'(IRT_LAST));

  // Abort and ir both take precedence over expiry.
  always_comb begin
    timeout_next = (state_reg == S_WAIT_IR) && !cmd_abort && !ir && wait_expired;
    ir_cnt_next  = (state_reg == S_WAIT_IR) ? ir_cnt_reg + IRT_W'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      ir_cnt_reg  <= ir_cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  assign timeout = timeout_reg;
`else
  assign wait_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_comb begin
    state_next      = state_reg;
    strength_next   = strength_reg;
    hold_cnt_next   = hold_cnt_reg;
    cd_cnt_next     = cd_cnt_reg;
    done_next       = 1'b0;
    kick_count_next = kick_count_reg;

    case (state_reg)
      S_IDLE: begin
        if (cmd_valid) begin
          strength_next = cmd_strength;
          // Strength 0 is a null shot: acknowledged with done, never fired or counted.
          if (cmd_strength == 4'd0) begin
            done_next = 1'b1;
          end else begin
            state_next = S_WAIT_IR;
          end
        end
      end

      S_WAIT_IR: begin
        if (cmd_abort) begin
          state_next = S_IDLE;
        end else if (ir) begin
          state_next    = S_FIRE;
          hold_cnt_next = '0;
        end else if (wait_expired) begin
          state_next = S_IDLE;
        end
      end

      S_FIRE: begin
        if (hold_cnt_reg == HOLD_W'(HOLD_LAST)) begin
          state_next  = S_COOLDOWN;
          cd_cnt_next = '0;
        end else begin
          hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
        end
      end

      S_COOLDOWN: begin
        // Counter parks at its last value while the driver still reports trigger.
        if (cd_cnt_reg == CD_W'(CD_LAST)) begin
          if (!trigger_in) begin
            state_next      = S_IDLE;
            done_next       = 1'b1;
            kick_count_next = kick_count_reg + 8'd1;
          end
        end else begin
          cd_cnt_next = cd_cnt_reg + CD_W'(1);
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      strength_reg   <= 4'd0;
      hold_cnt_reg   <= '0;
      cd_cnt_reg     <= '0;
      done_reg       <= 1'b0;
      kick_count_reg <= 8'd0;
    end else begin
      state_reg      <= state_next;
      strength_reg   <= strength_next;
      hold_cnt_reg   <= hold_cnt_next;
      cd_cnt_reg     <= cd_cnt_next;
      done_reg       <= done_next;
      kick_count_reg <= kick_count_next;
    end
  end

  assign cmd_ready  = (state_reg == S_IDLE);
  assign busy       = (state_reg != S_IDLE);
  assign kickstart  = (state_reg == S_FIRE);
  assign kicktime   = (state_reg == S_FIRE) ? strength_code(strength_reg) : 7'd0;
  assign done       = done_reg;
  assign kick_count = kick_count_reg;

endmodule

// File: tb/tb_kick_command_issuer.sv
// Bench for kick_command_issuer: directed scenarios plus random shots against a transaction-level model.
module tb_kick_command_issuer;
  localparam int HOLD = 4;
  localparam int CD   = 10;
  localparam int IRT  = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [3:0] cmd_strength;
  logic       cmd_abort;
  logic       ir;
  logic       trigger_in;
  logic       cmd_ready;
  logic       kickstart;
  logic [6:0] kicktime;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [7:0] kick_count;

  int compared   = 0;
  int mismatched = 0;
  int exp_count  = 0;
  logic [6:0] code_tbl [0:10];

  always #5 clk = ~clk;

  kick_command_issuer #(
    .HOLD_CYCLES(HOLD),
    .COOLDOWN_CYCLES(CD),
    .IR_TIMEOUT_CYCLES(IRT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_strength(cmd_strength),
    .cmd_abort(cmd_abort),
    .ir(ir),
    .trigger_in(trigger_in),
    .cmd_ready(cmd_ready),
    .kickstart(kickstart),
    .kicktime(kicktime),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .kick_count(kick_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [6:0] exp_code(input int s);
    int k;
    k = (s > 10) ? 10 : s;
    return code_tbl[k];
  endfunction

  task automatic accept(input int s);
    cmd_valid    = 1'b1;
    cmd_strength = 4'(s);
    tick();
    cmd_valid    = 1'b0;
  endtask

  // One full shot: ir rises in WAIT_IR cycle ir_delay, trigger_in held high for trig COOLDOWN cycles.
  task automatic run_shot(input int s, input int ir_delay, input int trig);
    int len;
    accept(s);
    if (s == 0) begin
      chk("null_done", done, 1);
      chk("null_busy", busy, 0);
      chk("null_count", kick_count, exp_count);
      tick();
      chk("null_done_end", done, 0);
      return;
    end
    for (int i = 0; i <= ir_delay; i++) begin
      chk("wait_busy", busy, 1);
      chk("wait_ready", cmd_ready, 0);
      chk("wait_kick", kickstart, 0);
      chk("wait_timeout", timeout, 0);
      cmd_valid    = 1'($urandom_range(0, 1));
      cmd_strength = 4'($urandom);
      ir           = (i == ir_delay);
      tick();
    end
    cmd_valid = 1'b0;
    for (int h = 0; h < HOLD; h++) begin
      chk("fire_kick", kickstart, 1);
      chk("fire_time", kicktime, exp_code(s));
      chk("fire_busy", busy, 1);
      chk("fire_done", done, 0);
      ir         = 1'($urandom_range(0, 1));
      cmd_abort  = 1'($urandom_range(0, 1));
      cmd_valid  = 1'($urandom_range(0, 1));
      trigger_in = (trig > 0);
      tick();
    end
    len = (trig + 1 > CD) ? trig + 1 : CD;
    for (int c = 0; c < len; c++) begin
      chk("cool_kick", kickstart, 0);
      chk("cool_time", kicktime, 0);
      chk("cool_busy", busy, 1);
      chk("cool_done", done, 0);
      trigger_in = (c < trig);
      cmd_abort  = 1'($urandom_range(0, 1));
      cmd_valid  = 1'($urandom_range(0, 1));
      ir         = 1'($urandom_range(0, 1));
      tick();
    end
    cmd_abort  = 1'b0;
    cmd_valid  = 1'b0;
    trigger_in = 1'b0;
    ir         = 1'b0;
    exp_count  = (exp_count + 1) % 256;
    chk("shot_done", done, 1);
    chk("shot_idle", busy, 0);
    chk("shot_ready", cmd_ready, 1);
    chk("shot_count", kick_count, exp_count);
    $display("shot strength=%0d ir_delay=%0d trig=%0d kick_count=%0d", s, ir_delay, trig, kick_count);
    tick();
    chk("shot_done_end", done, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    code_tbl = '{7'b0000000, 7'b0000001, 7'b0000011, 7'b0000111, 7'b0011111, 7'b1000000,
                 7'b1100000, 7'b1110000, 7'b1111000, 7'b1111100, 7'b1111110};
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_strength = 4'd0; cmd_abort = 1'b0;
    ir = 1'b0; trigger_in = 1'b0;

    // Reset values
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_kick", kickstart, 0);
      chk("rst_time", kicktime, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_count", kick_count, 0);
    end
    rst_n = 1'b1;
    tick();
    chk("rst_ready", cmd_ready, 1);
    $display("reset released");

    // Reset asserted in the second FIRE cycle
    accept(7);
    ir = 1'b1;
    tick();
    ir = 1'b0;
    chk("rf_fire0", kickstart, 1);
    tick();
    chk("rf_fire1", kickstart, 1);
    rst_n = 1'b0;
    tick();
    chk("rf_kick", kickstart, 0);
    chk("rf_time", kicktime, 0);
    chk("rf_busy", busy, 0);
    chk("rf_done", done, 0);
    chk("rf_count", kick_count, exp_count);
    rst_n = 1'b1;
    tick();
    chk("rf_ready", cmd_ready, 1);
    chk("rf_done_after", done, 0);
    $display("reset in FIRE kick_count=%0d", kick_count);

    run_shot(4, 3, 0);
    run_shot(0, 0, 0);
    $display("null command kick_count=%0d", kick_count);

    // Abort and ir together in WAIT_IR
    accept(9);
    chk("ab_wait", busy, 1);
    tick();
    chk("ab_wait2", busy, 1);
    cmd_abort = 1'b1;
    ir        = 1'b1;
    tick();
    chk("ab_idle", busy, 0);
    chk("ab_ready", cmd_ready, 1);
    chk("ab_kick", kickstart, 0);
    cmd_abort = 1'b0;
    ir        = 1'b0;
    tick();
    chk("ab_done", done, 0);
    chk("ab_kick2", kickstart, 0);
    chk("ab_count", kick_count, exp_count);
    $display("abort with ir kick_count=%0d", kick_count);

    // cmd_valid and cmd_abort together in IDLE
    cmd_abort = 1'b1;
    accept(6);
    chk("va_accepted", busy, 1);
    tick();
    chk("va_aborted", busy, 0);
    chk("va_done", done, 0);
    cmd_abort = 1'b0;
    tick();
    chk("va_done2", done, 0);
    chk("va_count", kick_count, exp_count);
    $display("valid+abort kick_count=%0d", kick_count);

    run_shot(2, 1, 25);
    run_shot(8, IRT - 1, 0);

`ifdef KICK_IR_TIMEOUT_EN
    accept(5);
    for (int i = 0; i < IRT; i++) begin
      chk("to_wait", busy, 1);
      chk("to_early", timeout, 0);
      tick();
    end
    chk("to_pulse", timeout, 1);
    chk("to_idle", busy, 0);
    chk("to_done", done, 0);
    tick();
    chk("to_pulse_end", timeout, 0);
    $display("ir timeout observed=%0b", timeout);
`else
    accept(5);
    for (int i = 0; i < 100; i++) begin
      chk("nt_wait", busy, 1);
      chk("nt_timeout", timeout, 0);
      tick();
    end
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    chk("nt_abort", busy, 0);
    tick();
    $display("no timeout after 100 WAIT_IR cycles");
`endif

    // Random shots until the counter sits at 255, then one more to wrap
    while (exp_count != 255) begin
      run_shot($urandom_range(0, 15), $urandom_range(0, 15),
               ($urandom_range(0, 1) == 1) ? $urandom_range(0, 14) : 0);
    end
    chk("pre_wrap", kick_count, 255);
    run_shot(13, 2, 0);
    chk("wrap_zero", kick_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
